// File: rtl/gemm_row_driver.sv
// gemm_row_driver: sequences one GEMM micro-command over a 16-lane MAC row.
// Latency: read issued at t, operands at t+2, accumulator write at t+3; one element per cycle.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid is ignored while a command is in flight.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   cmd_*                         command handshake and fields (bases, length, reset_acc)
//   inp_rd_*, wgt_rd_*, acc_rd_*  scratchpad read ports, data returns one cycle after enable
//   i_row, w_row, a_row, o_row    registered MAC operands out, combinational MAC result in
//   acc_wr_*                      accumulator write-back port
//   busy, done                    status: not-idle level, one-cycle completion pulse
// Build option: define GEMM_ROW_RELU_EN to clamp negative result lanes to zero on write-back.
module gemm_row_driver #(
  parameter int INP_WIDTH  = 8,
  parameter int WGT_WIDTH  = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int IT_WIDTH   = INP_WIDTH * 16,
  parameter int WT_WIDTH   = WGT_WIDTH * 16,
  parameter int AT_WIDTH   = ACC_WIDTH * 16,
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_inp_base,
  input  logic [ADDR_WIDTH-1:0] cmd_wgt_base,
  input  logic [ADDR_WIDTH-1:0] cmd_acc_base,
  input  logic [CNT_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_reset_acc,
  output logic                  inp_rd_en,
  output logic [ADDR_WIDTH-1:0] inp_rd_addr,
  input  logic [IT_WIDTH-1:0]   inp_rd_data,
  output logic                  wgt_rd_en,
  output logic [ADDR_WIDTH-1:0] wgt_rd_addr,
  input  logic [WT_WIDTH-1:0]   wgt_rd_data,
  output logic                  acc_rd_en,
  output logic [ADDR_WIDTH-1:0] acc_rd_addr,
  input  logic [AT_WIDTH-1:0]   acc_rd_data,
  output logic [IT_WIDTH-1:0]   i_row,
  output logic [WT_WIDTH-1:0]   w_row,
  output logic [AT_WIDTH-1:0]   a_row,
  input  logic [AT_WIDTH-1:0]   o_row,
  output logic                  acc_wr_en,
  output logic [ADDR_WIDTH-1:0] acc_wr_addr,
  output logic [AT_WIDTH-1:0]   acc_wr_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  k_q, len_q;
  logic [ADDR_WIDTH-1:0] inp_base_q, wgt_base_q, acc_base_q;
  logic                  racc_q;

  logic                  inp_rd_en_q, wgt_rd_en_q, acc_rd_en_q;
  logic [ADDR_WIDTH-1:0] inp_rd_addr_q, wgt_rd_addr_q, acc_rd_addr_q;
  logic                  v1_q, v2_q;
  logic [ADDR_WIDTH-1:0] wa1_q, wa2_q;
  logic [IT_WIDTH-1:0]   i_row_q;
  logic [WT_WIDTH-1:0]   w_row_q;
  logic [AT_WIDTH-1:0]   a_row_q;
  logic                  acc_wr_en_q;
  logic [ADDR_WIDTH-1:0] acc_wr_addr_q;
  logic [AT_WIDTH-1:0]   acc_wr_data_q;

  logic                  accept, issue, iss_racc;
  logic [CNT_WIDTH-1:0]  iss_k;
  logic [ADDR_WIDTH-1:0] iss_inp_addr, iss_wgt_addr, iss_acc_addr;
  logic [AT_WIDTH-1:0]   wr_data_d;

  // Next state and issue control. The first element is issued on the accept
  // edge straight from the command fields, so the first read lands at c+1.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    issue    = 1'b0;
    iss_k    = k_q;
    iss_racc = racc_q;
    iss_inp_addr = inp_base_q + ADDR_WIDTH'(k_q);
    iss_wgt_addr = wgt_base_q + ADDR_WIDTH'(k_q);
    iss_acc_addr = acc_base_q + ADDR_WIDTH'(k_q);
    case (state_q)
      S_IDLE: begin
        iss_k        = '0;
        iss_racc     = cmd_reset_acc;
        iss_inp_addr = cmd_inp_base;
        iss_wgt_addr = cmd_wgt_base;
        iss_acc_addr = cmd_acc_base;
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            issue   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (k_q < len_q) issue = 1'b1;
        else             state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Last write is on the port and nothing is behind it.
        if (acc_wr_en_q && !v1_q && !v2_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write-back data, optionally clamping negative lanes.
  always_comb begin
    wr_data_d = o_row;
`ifdef GEMM_ROW_RELU_EN
    for (int l = 0; l < 16; l++) begin
      if (o_row[l*ACC_WIDTH + ACC_WIDTH - 1]) wr_data_d[l*ACC_WIDTH +: ACC_WIDTH] = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      len_q         <= '0;
      inp_base_q    <= '0;
      wgt_base_q    <= '0;
      acc_base_q    <= '0;
      racc_q        <= 1'b0;
      inp_rd_en_q   <= 1'b0;
      wgt_rd_en_q   <= 1'b0;
      acc_rd_en_q   <= 1'b0;
      inp_rd_addr_q <= '0;
      wgt_rd_addr_q <= '0;
      acc_rd_addr_q <= '0;
      v1_q          <= 1'b0;
      v2_q          <= 1'b0;
      wa1_q         <= '0;
      wa2_q         <= '0;
      i_row_q       <= '0;
      w_row_q       <= '0;
      a_row_q       <= '0;
      acc_wr_en_q   <= 1'b0;
      acc_wr_addr_q <= '0;
      acc_wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        inp_base_q <= cmd_inp_base;
        wgt_base_q <= cmd_wgt_base;
        acc_base_q <= cmd_acc_base;
        len_q      <= cmd_len;
        racc_q     <= cmd_reset_acc;
      end
      // Stage t: read issue.
      inp_rd_en_q <= issue;
      wgt_rd_en_q <= issue;
      acc_rd_en_q <= issue & ~iss_racc;
      if (issue) begin
        k_q           <= iss_k + CNT_WIDTH'(1);
        inp_rd_addr_q <= iss_inp_addr;
        wgt_rd_addr_q <= iss_wgt_addr;
        acc_rd_addr_q <= iss_acc_addr;
      end
      // Stage t+1: read data returns, register operands.
      v1_q <= inp_rd_en_q;
      if (inp_rd_en_q) wa1_q <= acc_rd_addr_q;
      v2_q <= v1_q;
      if (v1_q) begin
        i_row_q <= inp_rd_data;
        w_row_q <= wgt_rd_data;
        a_row_q <= racc_q ? '0 : acc_rd_data;
        wa2_q   <= wa1_q;
      end
      // Stage t+2: capture MAC result; presented on the write port at t+3.
      acc_wr_en_q <= v2_q;
      if (v2_q) begin
        acc_wr_data_q <= wr_data_d;
        acc_wr_addr_q <= wa2_q;
      end
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign inp_rd_en   = inp_rd_en_q;
  assign wgt_rd_en   = wgt_rd_en_q;
  assign acc_rd_en   = acc_rd_en_q;
  assign inp_rd_addr = inp_rd_addr_q;
  assign wgt_rd_addr = wgt_rd_addr_q;
  assign acc_rd_addr = acc_rd_addr_q;
  assign i_row       = i_row_q;
  assign w_row       = w_row_q;
  assign a_row       = a_row_q;
  assign acc_wr_en   = acc_wr_en_q;
  assign acc_wr_addr = acc_wr_addr_q;
  assign acc_wr_data = acc_wr_data_q;

endmodule

// File: tb/tb_gemm_row_driver.sv
// Testbench for gemm_row_driver: scratchpad models with one-cycle reads, a
// combinational signed MAC row, and directed commands with hand-computed results.
module tb_gemm_row_driver;
  localparam int AW = 11;
  localparam int CW = 14;
  localparam int IT = 128;
  localparam int WT = 128;
  localparam int AT = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_reset_acc;
  logic [AW-1:0] cmd_inp_base, cmd_wgt_base, cmd_acc_base;
  logic [CW-1:0] cmd_len;
  logic          inp_rd_en, wgt_rd_en, acc_rd_en, acc_wr_en, busy, done;
  logic [AW-1:0] inp_rd_addr, wgt_rd_addr, acc_rd_addr, acc_wr_addr;
  logic [IT-1:0] inp_rd_data, i_row;
  logic [WT-1:0] wgt_rd_data, w_row;
  logic [AT-1:0] acc_rd_data, a_row, o_row, acc_wr_data;

  always #5 clk = ~clk;

  gemm_row_driver dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_inp_base(cmd_inp_base), .cmd_wgt_base(cmd_wgt_base), .cmd_acc_base(cmd_acc_base),
    .cmd_len(cmd_len), .cmd_reset_acc(cmd_reset_acc),
    .inp_rd_en(inp_rd_en), .inp_rd_addr(inp_rd_addr), .inp_rd_data(inp_rd_data),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
    .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
    .i_row(i_row), .w_row(w_row), .a_row(a_row), .o_row(o_row),
    .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data),
    .busy(busy), .done(done)
  );

  // Scratchpad models.
  logic [IT-1:0] inp_mem [0:2047];
  logic [WT-1:0] wgt_mem [0:2047];
  logic [AT-1:0] acc_mem [0:2047];

  always @(posedge clk) begin
    if (inp_rd_en) inp_rd_data <= inp_mem[inp_rd_addr];
    if (wgt_rd_en) wgt_rd_data <= wgt_mem[wgt_rd_addr];
    if (acc_rd_en) acc_rd_data <= acc_mem[acc_rd_addr];
  end

  // Combinational MAC row: per lane a + signed(i) * signed(w), wrapping at 32 bits.
  function automatic logic [AT-1:0] mac(input logic [IT-1:0] i, input logic [WT-1:0] w,
                                        input logic [AT-1:0] a);
    logic [AT-1:0]      r;
    logic signed [31:0] p;
    for (int l = 0; l < 16; l++) begin
      p = $signed(i[l*8 +: 8]) * $signed(w[l*8 +: 8]);
      r[l*32 +: 32] = a[l*32 +: 32] + p;
    end
    return r;
  endfunction

  always_comb o_row = mac(i_row, w_row, a_row);

  function automatic logic [IT-1:0] rep8(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [AT-1:0] rep32(input logic [31:0] v);
    return {16{v}};
  endfunction

  // Cycle counter and port monitor.
  int            cyc = 0;
  int            rd_cyc[$];
  logic [AW-1:0] inp_ra[$], wgt_ra[$], wr_a[$];
  int            wr_c[$];
  logic [AT-1:0] wr_d[$];
  int            acc_rd_cnt, done_cnt;

  initial forever @(posedge clk) cyc++;

  initial forever begin
    @(negedge clk);
    if (inp_rd_en) begin rd_cyc.push_back(cyc); inp_ra.push_back(inp_rd_addr); end
    if (wgt_rd_en) wgt_ra.push_back(wgt_rd_addr);
    if (acc_rd_en) acc_rd_cnt++;
    if (acc_wr_en) begin
      wr_a.push_back(acc_wr_addr);
      wr_c.push_back(cyc);
      wr_d.push_back(acc_wr_data);
    end
    if (done) done_cnt++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); inp_ra.delete(); wgt_ra.delete();
    wr_a.delete(); wr_c.delete(); wr_d.delete();
    acc_rd_cnt = 0; done_cnt = 0;
  endtask

  // Offers a command at a negedge; returns the accept cycle.
  task automatic run_cmd(input logic [AW-1:0] ib, input logic [AW-1:0] wb, input logic [AW-1:0] ab,
                         input int len, input logic racc, output int c);
    @(negedge clk);
    clear_logs();
    cmd_inp_base  = ib;
    cmd_wgt_base  = wb;
    cmd_acc_base  = ab;
    cmd_len       = CW'(len);
    cmd_reset_acc = racc;
    cmd_valid     = 1'b1;
    c = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  logic [31:0] exp_neg;

  initial begin
    int c;
    rst = 1'b1; cmd_valid = 1'b0; cmd_inp_base = '0; cmd_wgt_base = '0; cmd_acc_base = '0;
    cmd_len = '0; cmd_reset_acc = 1'b0;
    for (int a = 0; a < 2048; a++) begin
      inp_mem[a] = '0; wgt_mem[a] = '0; acc_mem[a] = '0;
    end
    clear_logs();
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_en", 64'({inp_rd_en, wgt_rd_en, acc_rd_en}), 64'd0);
    chk("rst_wr_en", 64'(acc_wr_en), 64'd0);
    chk("rst_addrs", 64'({inp_rd_addr, wgt_rd_addr, acc_rd_addr, acc_wr_addr}), 64'd0);
    chk("rst_rows_zero", 64'((i_row == '0) && (w_row == '0) && (a_row == '0) && (acc_wr_data == '0)), 64'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Test 1: single element, 10 + 2*3 = 16 per lane.
    inp_mem[0] = rep8(8'd2); wgt_mem[0] = rep8(8'd3); acc_mem[0] = rep32(32'd10);
    run_cmd(11'd0, 11'd0, 11'd0, 1, 1'b0, c);
    chk("t1_ready_drop", 64'(cmd_ready), 64'd0);
    wait_done("t1");
    chk("t1_done_cyc", 64'(cyc - c), 64'd5);
    chk("t1_done_after_rd", 64'(cyc - rd_cyc[0]), 64'd4);
    chk("t1_ready_in_done", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("t1_ready_back", 64'(cmd_ready), 64'd1);
    chk("t1_busy_low", 64'(busy), 64'd0);
    chk("t1_wr_n", 64'(wr_a.size()), 64'd1);
    chk("t1_wr_addr", 64'(wr_a[0]), 64'd0);
    chk("t1_wr_cyc", 64'(wr_c[0] - c), 64'd4);
    chk("t1_lane0", 64'(wr_d[0][31:0]), 64'd16);
    chk("t1_lane15", 64'(wr_d[0][511:480]), 64'd16);
    chk("t1_acc_rd", 64'(acc_rd_cnt), 64'd1);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);

    // Test 2: reset_acc, four elements, acc contents ignored -> 2*(k+1).
    for (int k = 0; k < 4; k++) begin
      inp_mem[8+k]  = rep8(8'(k + 1));
      wgt_mem[16+k] = rep8(8'd2);
      acc_mem[32+k] = rep32(32'd1000);
    end
    run_cmd(11'd8, 11'd16, 11'd32, 4, 1'b1, c);
    wait_done("t2");
    chk("t2_done_cyc", 64'(cyc - c), 64'd8);
    @(negedge clk);
    chk("t2_acc_rd_never", 64'(acc_rd_cnt), 64'd0);
    chk("t2_rd_n", 64'(inp_ra.size()), 64'd4);
    chk("t2_wr_n", 64'(wr_a.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_inp_addr%0d", k), 64'(inp_ra[k]), 64'(8 + k));
      chk($sformatf("t2_wgt_addr%0d", k), 64'(wgt_ra[k]), 64'(16 + k));
      chk($sformatf("t2_wr_addr%0d", k), 64'(wr_a[k]), 64'(32 + k));
      chk($sformatf("t2_wr_cyc%0d", k), 64'(wr_c[k] - c), 64'(4 + k));
      chk($sformatf("t2_lane0_%0d", k), 64'(wr_d[k][31:0]), 64'(2 * (k + 1)));
      chk($sformatf("t2_lane15_%0d", k), 64'(wr_d[k][511:480]), 64'(2 * (k + 1)));
    end

    // Test 3: zero-length command.
    run_cmd(11'd5, 11'd6, 11'd7, 0, 1'b0, c);
    wait_done("t3");
    chk("t3_done_cyc", 64'(cyc - c), 64'd1);
    repeat (4) @(negedge clk);
    chk("t3_no_rd", 64'(rd_cyc.size() + acc_rd_cnt), 64'd0);
    chk("t3_no_wr", 64'(wr_a.size()), 64'd0);
    chk("t3_done_once", 64'(done_cnt), 64'd1);

    // Test 4: address wrap on acc and inp bases.
    run_cmd(11'h7FF, 11'h000, 11'h7FE, 3, 1'b1, c);
    wait_done("t4");
    @(negedge clk);
    chk("t4_wr_n", 64'(wr_a.size()), 64'd3);
    chk("t4_wr0", 64'(wr_a[0]), 64'h7FE);
    chk("t4_wr1", 64'(wr_a[1]), 64'h7FF);
    chk("t4_wr2", 64'(wr_a[2]), 64'h000);
    chk("t4_inp0", 64'(inp_ra[0]), 64'h7FF);
    chk("t4_inp1", 64'(inp_ra[1]), 64'h000);
    chk("t4_inp2", 64'(inp_ra[2]), 64'h001);

    // Test 5: reset two cycles into an 8-element command.
    run_cmd(11'd0, 11'd0, 11'd64, 8, 1'b0, c);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_idle_after_rst", 64'(busy), 64'd0);
    chk("t5_rd_off", 64'({inp_rd_en, wgt_rd_en, acc_rd_en}), 64'd0);
    @(negedge clk);
    chk("t5_ready", 64'(cmd_ready), 64'd1);
    repeat (12) @(negedge clk);
    chk("t5_no_wr", 64'(wr_a.size()), 64'd0);
    chk("t5_no_done", 64'(done_cnt), 64'd0);
    chk("t5_two_reads", 64'(rd_cyc.size()), 64'd2);

    // Test 6: negative result lane (-1 * 5 = -5), positive lane 1 * 5 = 5.
    inp_mem[100] = {{15{8'h01}}, 8'hFF};
    wgt_mem[100] = rep8(8'd5);
    acc_mem[100] = rep32(32'd0);
`ifdef GEMM_ROW_RELU_EN
    exp_neg = 32'h0000_0000;
`else
    exp_neg = 32'hFFFF_FFFB;
`endif
    run_cmd(11'd100, 11'd100, 11'd100, 1, 1'b0, c);
    wait_done("t6");
    @(negedge clk);
    chk("t6_wr_n", 64'(wr_a.size()), 64'd1);
    chk("t6_lane0_neg", 64'(wr_d[0][31:0]), 64'(exp_neg));
    chk("t6_lane1_pos", 64'(wr_d[0][63:32]), 64'd5);
    chk("t6_wr_cyc", 64'(wr_c[0] - c), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
